tmds_decoder_dvi: RTL and testbench
===================================

Name: tmds_decoder_dvi

Overview:
- Receive-side counterpart of the DVI TMDS encoder: one instance per TMDS data channel, pixel-clock domain.
- Consumes 10-bit parallel words from an external 1:10 deserializer.
- Aligns word boundaries by issuing bitslip pulses until a run of TMDS control tokens is seen.
- Once locked, decodes each word back to 8-bit colour data, 2-bit control data and display enable.

Parameters:
- LOCK_TOKENS, 8: consecutive control tokens required to declare lock.
- SEARCH_CYCLES, 2048: cycles spent at one slip position before the next bitslip.
- SLIP_WAIT, 4: cycles ignored after a bitslip pulse, covering deserializer settling.
- LOST_CYCLES, 4096: cycles in LOCKED with no control token before lock is dropped.

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  reset, asynchronous, active-high
- i_tmds  in  10  parallel TMDS word; bit 0 is the first serial bit
- o_bitslip  out  1  single-cycle bitslip request to the deserializer
- o_locked  out  1  high when o_data/o_ctrl/o_de carry decoded words
- o_data  out  8  decoded colour data
- o_ctrl  out  2  decoded control data
- o_de  out  1  display enable (1 = data word, 0 = control token)

Behaviour:
- Reset (async assert, sync release): state SEARCH, all counters 0, all outputs 0.
- Control tokens, written bit 9..0:
  - 1101010100 -> ctrl 00
  - 0010101011 -> ctrl 01
  - 0101010100 -> ctrl 10
  - 1010101011 -> ctrl 11
- Any other word is a data word. Decode:
  - q = tmds[9] ? ~tmds[7:0] : tmds[7:0]
  - d[0] = q[0]
  - for i = 1..7: d[i] = tmds[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1])
- FSM states SEARCH, SLIP, WAIT, LOCKED:
  - SEARCH: window counter increments every cycle; run counter increments on a control token and clears on a data word.
    - Run reaches LOCK_TOKENS on the sampled word -> LOCKED next cycle. This takes priority over window expiry in the same cycle.
    - Window counter reaches SEARCH_CYCLES-1 without lock -> SLIP.
  - SLIP: o_bitslip = 1 for exactly one cycle -> WAIT.
  - WAIT: count SLIP_WAIT cycles, input ignored -> SEARCH with window and run counters cleared.
  - LOCKED: a silence counter clears on every control token.
    - Silence counter reaches LOST_CYCLES -> SEARCH, counters cleared.
- Slip positions wrap naturally: the deserializer cycles through 10 positions, so the block never stops retrying.
- Output timing:
  - Outputs are registered; latency is 1 cycle.
  - A word sampled at edge k while state == LOCKED appears on o_data/o_ctrl/o_de at k+1, with o_locked = 1.
  - A word sampled in any other state gives o_locked = 0, o_data = 0, o_ctrl = 0, o_de = 0 at k+1.
- Output content per decoded word:
  - Control token: o_de = 0, o_ctrl = token value, o_data = 0.
  - Data word: o_de = 1, o_data = d, o_ctrl holds its last value.
- First decoded word: the word after the LOCK_TOKENS-th token. o_locked rises 2 cycles after that token was sampled.
- Loss of lock: the last decoded word is the one sampled in the LOCKED cycle where the silence counter hits its limit. o_locked falls on the following cycle.
- o_bitslip is never asserted outside SLIP. Minimum spacing between pulses is SEARCH_CYCLES+SLIP_WAIT+1 cycles.
- Counter widths: $clog2(param+1). No counter wraps; each saturates or clears per the transitions above.
- Reset mid-operation: immediate return to reset values from any state, including during an o_bitslip pulse.

Test Plan (SEARCH_CYCLES=64, SLIP_WAIT=4, LOCK_TOKENS=8, LOST_CYCLES=128; the bench deserializer model rotates one bit per slip pulse):
1. Reset held 5 cycles with random i_tmds -> all outputs 0, no o_bitslip. After release, no o_bitslip for 64 cycles.
2. Aligned stream of 8×1101010100 then 0100000000 then 1011111111:
   - o_locked rises 2 cycles after the 8th token.
   - Then o_de=1, o_data=8'h00; next cycle o_data=8'hFE.
   - Then a 0101010100 token gives o_de=0, o_ctrl=2'b10.
3. Stream misaligned by 3 bits -> exactly 3 o_bitslip pulses, each one cycle wide, spaced 69 cycles apart. Lock follows on the first clean 8-token run; the decoded data matches the transmitted data.
4. 7 tokens, 1 data word, then tokens (aligned) -> o_locked stays 0 until 8 new consecutive tokens arrive. No slip occurs if that run completes within the window.
5. Locked, then 128 consecutive data words -> o_locked falls and outputs go 0. o_bitslip fires 64 cycles later if no token run reappears.
6. Async reset asserted mid-data while locked, between clock edges -> outputs 0 immediately. Relock requires a full 8-token run.

Source files
------------

// File: rtl/tmds_decoder_dvi.sv
// Receive-side DVI TMDS channel decoder: hunts for word alignment with bitslip pulses
// until a run of control tokens is seen, then decodes words to data/ctrl/de.
module tmds_decoder_dvi #(
  parameter int LOCK_TOKENS   = 8,
  parameter int SEARCH_CYCLES = 2048,
  parameter int SLIP_WAIT     = 4,
  parameter int LOST_CYCLES   = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_tmds,
  output logic       o_bitslip,
  output logic       o_locked,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de
);

  localparam int RUN_W  = $clog2(LOCK_TOKENS + 1);
  localparam int WIN_W  = $clog2(SEARCH_CYCLES + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int SIL_W  = $clog2(LOST_CYCLES + 1);

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_TOKENS);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [SIL_W-1:0]  SIL_LAST  = SIL_W'(LOST_CYCLES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t             state_r;
  logic [RUN_W-1:0]   run_r;
  logic [WIN_W-1:0]   win_r;
  logic [WAIT_W-1:0]  wait_r;
  logic [SIL_W-1:0]   sil_r;

  logic               token_s;
  logic [1:0]         token_val_s;
  logic [7:0]         data_dec_s;
  logic [RUN_W-1:0]   run_inc_s;
  logic [WIN_W-1:0]   win_inc_s;
  logic [WAIT_W-1:0]  wait_inc_s;
  logic [SIL_W-1:0]   sil_inc_s;

  // Returns {is_token, ctrl_value} for the four DVI control tokens.
  function automatic logic [2:0] token_lookup(input logic [9:0] w);
    case (w)
      10'b1101010100: token_lookup = 3'b100;
      10'b0010101011: token_lookup = 3'b101;
      10'b0101010100: token_lookup = 3'b110;
      10'b1010101011: token_lookup = 3'b111;
      default:        token_lookup = 3'b000;
    endcase
  endfunction

  // Undo the transition-minimising stage: bit 9 inverts, bit 8 selects XOR vs XNOR chain.
  function automatic logic [7:0] decode_data(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

  // Word classification and counter increments.
  always_comb begin
    {token_s, token_val_s} = token_lookup(i_tmds);
    data_dec_s             = decode_data(i_tmds);
    run_inc_s              = run_r + RUN_W'(1);
    win_inc_s              = win_r + WIN_W'(1);
    wait_inc_s             = wait_r + WAIT_W'(1);
    sil_inc_s              = sil_r + SIL_W'(1);
  end

  // Alignment FSM with registered decoded outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_SEARCH;
      run_r     <= '0;
      win_r     <= '0;
      wait_r    <= '0;
      sil_r     <= '0;
      o_bitslip <= 1'b0;
      o_locked  <= 1'b0;
      o_data    <= 8'h00;
      o_ctrl    <= 2'b00;
      o_de      <= 1'b0;
    end else begin
      o_bitslip <= 1'b0;
      o_locked  <= 1'b0;
      o_data    <= 8'h00;
      o_ctrl    <= 2'b00;
      o_de      <= 1'b0;
      case (state_r)
        ST_SEARCH: begin
          if (token_s && (run_inc_s == RUN_LAST)) begin
            // Lock wins over window expiry on the same word.
            state_r <= ST_LOCKED;
            run_r   <= '0;
            win_r   <= '0;
            sil_r   <= '0;
          end else if (win_r == WIN_LAST) begin
            state_r   <= ST_SLIP;
            o_bitslip <= 1'b1;
            run_r     <= '0;
            win_r     <= '0;
          end else begin
            run_r <= token_s ? run_inc_s : '0;
            win_r <= win_inc_s;
          end
        end
        ST_SLIP: begin
          state_r <= ST_WAIT;
          wait_r  <= '0;
        end
        ST_WAIT: begin
          if (wait_r == WAIT_LAST) begin
            state_r <= ST_SEARCH;
            wait_r  <= '0;
            run_r   <= '0;
            win_r   <= '0;
          end else begin
            wait_r <= wait_inc_s;
          end
        end
        ST_LOCKED: begin
          o_locked <= 1'b1;
          if (token_s) begin
            o_ctrl <= token_val_s;
            sil_r  <= '0;
          end else begin
            o_de   <= 1'b1;
            o_data <= data_dec_s;
            o_ctrl <= o_ctrl;
            if (sil_inc_s == SIL_LAST) begin
              state_r <= ST_SEARCH;
              sil_r   <= '0;
              run_r   <= '0;
              win_r   <= '0;
            end else begin
              sil_r <= sil_inc_s;
            end
          end
        end
        default: begin
          state_r <= ST_SEARCH;
          run_r   <= '0;
          win_r   <= '0;
          wait_r  <= '0;
          sil_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder_dvi.sv
// Bench for tmds_decoder_dvi: deserializer model with bit rotation per slip, a
// cycle-level reference model, a fixed vector table and targeted corner sequences.
module tb_tmds_decoder_dvi;

  localparam int LT = 8;
  localparam int SC = 64;
  localparam int SW = 4;
  localparam int LC = 128;

  localparam int M_SEARCH = 0;
  localparam int M_SLIP   = 1;
  localparam int M_WAIT   = 2;
  localparam int M_LOCKED = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] tmds = 10'h000;
  logic       o_bitslip, o_locked, o_de;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;

  tmds_decoder_dvi #(
    .LOCK_TOKENS(LT), .SEARCH_CYCLES(SC), .SLIP_WAIT(SW), .LOST_CYCLES(LC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_tmds(tmds), .o_bitslip(o_bitslip),
    .o_locked(o_locked), .o_data(o_data), .o_ctrl(o_ctrl), .o_de(o_de)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
  localparam logic [9:0] T00 = 10'b1101010100;

  // reference model state, expressed as deadlines in absolute edge numbers
  int mode, edge_n, search_start, wait_start, run, sil;
  logic       exp_bs, exp_lk, exp_de;
  logic [1:0] exp_ctrl;
  logic [7:0] exp_data;

  // deserializer model: rx word = bits [sh +: 10] of {newest tx, previous tx}; sh=10 is aligned
  int         sh = 10;
  logic [9:0] prev_tx = 10'h000;
  int         pulses[$];

  typedef struct {
    logic [9:0] tmds;
    logic       lk;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } vec_t;
  vec_t vecs [15];

  function automatic int tok_idx(input logic [9:0] w);
    for (int i = 0; i < 4; i++) if (w == tok_tab[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q = w[9] ? ~w[7:0] : w[7:0];
    d = q ^ {q[6:0], 1'b0};
    if (!w[8]) d = d ^ 8'hFE;
    return d;
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom_range(0, 1023));
    while (tok_idx(w) >= 0) w = 10'($urandom_range(0, 1023));
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    mode = M_SEARCH; run = 0; sil = 0;
    exp_bs = 1'b0; exp_lk = 1'b0; exp_de = 1'b0; exp_ctrl = 2'b00; exp_data = 8'h00;
  endtask

  task automatic model_edge(input logic [9:0] w);
    int t;
    logic [1:0] held;
    t = tok_idx(w);
    held = exp_ctrl;
    edge_n++;
    exp_bs = 1'b0; exp_lk = 1'b0; exp_de = 1'b0; exp_ctrl = 2'b00; exp_data = 8'h00;
    if (rst) begin
      model_reset();
      search_start = edge_n + 1;
      return;
    end
    case (mode)
      M_SEARCH: begin
        run = (t >= 0) ? run + 1 : 0;
        if (run == LT) begin
          mode = M_LOCKED; sil = 0;
        end else if (edge_n - search_start == SC - 1) begin
          mode = M_SLIP; exp_bs = 1'b1;
        end
      end
      M_SLIP: begin
        mode = M_WAIT; wait_start = edge_n + 1;
      end
      M_WAIT: begin
        if (edge_n - wait_start == SW - 1) begin
          mode = M_SEARCH; search_start = edge_n + 1; run = 0;
        end
      end
      default: begin
        exp_lk = 1'b1;
        if (t >= 0) begin
          exp_ctrl = t[1:0]; sil = 0;
        end else begin
          exp_de = 1'b1; exp_data = ref_decode(w); exp_ctrl = held; sil++;
          if (sil == LC) begin
            mode = M_SEARCH; search_start = edge_n + 1; run = 0;
          end
        end
      end
    endcase
  endtask

  // one clock: shift tx word through the deserializer, drive, clock, compare
  task automatic step(input logic [9:0] word);
    logic [19:0] cat;
    cat = {word, prev_tx} >> sh;
    prev_tx = word;
    @(negedge clk);
    tmds = cat[9:0];
    @(posedge clk);
    model_edge(cat[9:0]);
    #1;
    chk("outputs", 32'({o_bitslip, o_locked, o_de, o_ctrl, o_data}),
        32'({exp_bs, exp_lk, exp_de, exp_ctrl, exp_data}));
    if (o_bitslip) begin
      pulses.push_back(edge_n);
      sh = (sh == 10) ? 1 : sh + 1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    sh = 10;
    repeat (n) step(rand_data());
    rst = 1'b0;
    pulses.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    edge_n = 0; search_start = 1; wait_start = 0;
    model_reset();

    // 1: reset with random input, then a full window without a slip
    do_reset(5);
    chk("rst_outputs", 32'({o_bitslip, o_locked, o_de, o_ctrl, o_data}), 32'(0));
    repeat (63) step(rand_data());
    chk("no_early_slip", 32'(pulses.size()), 32'(0));
    step(rand_data());
    chk("first_slip_at_64", 32'(o_bitslip), 32'(1'b1));

    // 2: vector table on an aligned stream
    for (int i = 0; i < 8; i++) vecs[i] = '{T00, 1'b0, 1'b0, 2'b00, 8'h00};
    vecs[8]  = '{10'b0100000000, 1'b1, 1'b1, 2'b00, 8'h00};
    vecs[9]  = '{10'b1011111111, 1'b1, 1'b1, 2'b00, 8'hFE};
    vecs[10] = '{10'b0101010100, 1'b1, 1'b0, 2'b10, 8'h00};
    vecs[11] = '{10'b1010101010, 1'b1, 1'b1, 2'b10, 8'h01};
    vecs[12] = '{10'b1010101011, 1'b1, 1'b0, 2'b11, 8'h00};
    vecs[13] = '{10'b0111110000, 1'b1, 1'b1, 2'b11, 8'h10};
    vecs[14] = '{10'b1101010100, 1'b1, 1'b0, 2'b00, 8'h00};
    do_reset(3);
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].tmds);
      chk($sformatf("vec%0d", i), 32'({o_bitslip, o_locked, o_de, o_ctrl, o_data}),
          32'({1'b0, vecs[i].lk, vecs[i].de, vecs[i].ctrl, vecs[i].data}));
    end

    // 3: stream misaligned by 3 bits, blanking blocks of 12 tokens every 32 words
    do_reset(3);
    sh = 7;
    for (int c = 0; c < 600; c++) begin
      logic [9:0] w;
      w = ((c % 32) < 12) ? T00 : rand_data();
      step(w);
      if (o_locked && o_de) chk("tx_data", 32'(o_data), 32'(ref_decode(w)));
    end
    chk("slip_count", 32'(pulses.size()), 32'(3));
    for (int i = 1; i < pulses.size(); i++)
      chk("slip_spacing", 32'(pulses[i] - pulses[i-1]), 32'(SC + SW + 1));
    chk("locked_after_align", 32'(o_locked), 32'(1'b1));

    // 4: broken token run must restart the count
    do_reset(3);
    repeat (7) step(T00);
    step(rand_data());
    repeat (7) step(T00);
    chk("run_broken", 32'(o_locked), 32'(1'b0));
    step(T00);
    chk("lock_latency", 32'(o_locked), 32'(1'b0));
    step(rand_data());
    chk("relock", 32'(o_locked), 32'(1'b1));
    chk("no_slip_in_window", 32'(pulses.size()), 32'(0));

    // 5: loss of lock after LC data words, then a slip one window later
    do_reset(3);
    repeat (8) step(T00);
    repeat (LC - 1) step(rand_data());
    chk("still_locked", 32'(o_locked), 32'(1'b1));
    step(rand_data());
    chk("last_decoded", 32'({o_locked, o_de}), 32'(2'b11));
    n = 0;
    do begin
      step(rand_data());
      n++;
      if (n == 1) chk("lock_lost", 32'({o_locked, o_de, o_ctrl, o_data}), 32'(0));
    end while (!o_bitslip && n < 200);
    chk("slip_after_loss", 32'(n), 32'(SC));

    // 6: async reset between edges while locked
    do_reset(3);
    repeat (8) step(T00);
    repeat (5) step(rand_data());
    #2 rst = 1'b1;
    #1;
    chk("async_reset", 32'({o_bitslip, o_locked, o_de, o_ctrl, o_data}), 32'(0));
    model_reset();
    repeat (2) step(rand_data());
    rst = 1'b0;
    repeat (7) step(T00);
    step(rand_data());
    chk("no_lock_after_reset", 32'(o_locked), 32'(1'b0));
    repeat (8) step(T00);
    step(rand_data());
    chk("relock_after_reset", 32'(o_locked), 32'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
